// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional bypass outputs toward the read ports are enabled by defining RF_WRITE_ARB_FWD_EN.
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [ADDR_W-1:0]         RF_A3,
    output logic [DATA_W-1:0]         RF_WD3,
    output logic                      RF_WE,
`ifdef RF_WRITE_ARB_FWD_EN
    input  logic [ADDR_W-1:0]         RA1,
    input  logic [ADDR_W-1:0]         RA2,
    output logic                      FWD1_VLD,
    output logic                      FWD2_VLD,
    output logic [DATA_W-1:0]         FWD_DATA,
`endif
    output logic                      BUSY
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]            prio_reg;
    logic [PW-1:0]            prio_next;
    logic                     we_reg;
    logic [ADDR_W-1:0]        a3_reg;
    logic [DATA_W-1:0]        wd3_reg;

    logic [ADDR_W-1:0]        addr_arr [NUM_REQ];
    logic [DATA_W-1:0]        data_arr [NUM_REQ];
    logic [2*NUM_REQ-1:0]     req_dbl;
    logic [2*NUM_REQ-1:0]     req_rot;
    logic                     found;
    logic [PW-1:0]            off;
    logic [PW:0]              sum;
    logic [PW-1:0]            win_idx;
    logic [NUM_REQ-1:0]       gnt_raw;
    logic [ADDR_W-1:0]        win_addr;
    logic [DATA_W-1:0]        win_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = REQ_ADDR[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = REQ_DATA[gi*DATA_W +: DATA_W];
            assign gnt_raw[gi]  = found && (win_idx == PW'(gi));
        end
    endgenerate

    // Rotating a doubled copy puts the current priority holder at bit 0.
    assign req_dbl = {REQ, REQ};
    assign req_rot = req_dbl >> prio_reg;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = PW'(k);
            end
        end
    end

    assign sum       = {1'b0, prio_reg} + {1'b0, off};
    assign win_idx   = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
    assign prio_next = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_raw[i]) begin
                win_addr = addr_arr[i];
                win_data = data_arr[i];
            end
        end
    end

    assign GNT  = RST ? gnt_raw : '0;
    assign BUSY = |(REQ & ~GNT);

    // Address 0 writes and idle cycles both park the port on register 0 with enable low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prio_reg <= '0;
            we_reg   <= 1'b0;
            a3_reg   <= '0;
            wd3_reg  <= '0;
        end else if (found && (win_addr != '0)) begin
            prio_reg <= prio_next;
            we_reg   <= 1'b1;
            a3_reg   <= win_addr;
            wd3_reg  <= win_data;
        end else begin
            if (found) begin
                prio_reg <= prio_next;
            end
            we_reg  <= 1'b0;
            a3_reg  <= '0;
            wd3_reg <= '0;
        end
    end

    assign RF_WE  = we_reg;
    assign RF_A3  = a3_reg;
    assign RF_WD3 = wd3_reg;

`ifdef RF_WRITE_ARB_FWD_EN
    assign FWD1_VLD = we_reg && (a3_reg == RA1) && (RA1 != '0);
    assign FWD2_VLD = we_reg && (a3_reg == RA2) && (RA2 != '0);
    assign FWD_DATA = wd3_reg;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes expected writes, a monitor checks the write port.
// Bypass checks are compiled in when RF_WRITE_ARB_FWD_EN is defined.
module tb_rf_write_arbiter;

    logic        CLK;
    logic        RST;
    logic [2:0]  REQ;
    logic [14:0] REQ_ADDR;
    logic [95:0] REQ_DATA;
    logic [2:0]  GNT;
    logic [4:0]  RF_A3;
    logic [31:0] RF_WD3;
    logic        RF_WE;
    logic        BUSY;
`ifdef RF_WRITE_ARB_FWD_EN
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic        FWD1_VLD;
    logic        FWD2_VLD;
    logic [31:0] FWD_DATA;
`endif

    rf_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
        .GNT      (GNT),
        .RF_A3    (RF_A3),
        .RF_WD3   (RF_WD3),
        .RF_WE    (RF_WE),
`ifdef RF_WRITE_ARB_FWD_EN
        .RA1      (RA1),
        .RA2      (RA2),
        .FWD1_VLD (FWD1_VLD),
        .FWD2_VLD (FWD2_VLD),
        .FWD_DATA (FWD_DATA),
`endif
        .BUSY     (BUSY)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every performed write must match the oldest expected one, in the expected cycle.
    always @(negedge CLK) begin
        if (RF_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write cycle=%0d actual=a3:%0d wd3:%h required=no write", cyc, RF_A3, RF_WD3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_a3", RF_A3, e.a);
                chk("write_wd3", RF_WD3, e.d);
            end
        end else begin
            chk("park_a3", RF_A3, 0);
            chk("park_wd3", RF_WD3, 0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write cycle=%0d actual=we:0 required=a3:%0d wd3:%h", cyc, exp_q[0].a, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input string name, input logic [2:0] req, input logic [14:0] addr,
                         input logic [95:0] data, input logic [2:0] exp_gnt, input logic exp_busy);
        @(posedge CLK);
        #1;
        REQ      = req;
        REQ_ADDR = addr;
        REQ_DATA = data;
        @(negedge CLK);
        chk({name, "_gnt"}, GNT, exp_gnt);
        chk({name, "_busy"}, BUSY, exp_busy);
        for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i] && addr[i*5 +: 5] != 5'd0)
                exp_q.push_back('{cyc + 1, addr[i*5 +: 5], data[i*32 +: 32]});
        end
    endtask

    localparam logic [14:0] ADDR3 = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] DATA3 = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};

    initial begin
        REQ      = '0;
        REQ_ADDR = '0;
        REQ_DATA = '0;
`ifdef RF_WRITE_ARB_FWD_EN
        RA1 = '0;
        RA2 = '0;
`endif
        RST = 1'b1;
        #2 RST = 1'b0;
        @(posedge CLK);
        #1 REQ = 3'b111;
        @(negedge CLK);
        chk("reset_gnt", GNT, 3'b000);
        chk("reset_we", RF_WE, 1'b0);
        REQ = '0;
        @(posedge CLK);
        #1 RST = 1'b1;

        for (int n = 0; n < 5; n++)
            drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);

        drive("all0", 3'b111, ADDR3, DATA3, 3'b001, 1'b1);
        drive("all1", 3'b111, ADDR3, DATA3, 3'b010, 1'b1);
        drive("all2", 3'b111, ADDR3, DATA3, 3'b100, 1'b1);
        drive("all3", 3'b111, ADDR3, DATA3, 3'b001, 1'b1);
        drive("all4", 3'b111, ADDR3, DATA3, 3'b010, 1'b1);
        drive("all5", 3'b111, ADDR3, DATA3, 3'b100, 1'b1);

        drive("single", 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b010, 1'b0);
        drive("prio2", 3'b111, ADDR3, DATA3, 3'b100, 1'b1);

        drive("addr0", 3'b001, 15'd0, {64'd0, 32'h0000_1234}, 3'b001, 1'b0);
        drive("prio1", 3'b011, {5'd0, 5'd2, 5'd4}, {32'd0, 32'h22, 32'h11}, 3'b010, 1'b1);
        drive("hold0", 3'b001, {5'd0, 5'd2, 5'd4}, {32'd0, 32'h22, 32'h11}, 3'b001, 1'b0);

        drive("same_a", 3'b101, {5'd10, 5'd0, 5'd10}, {32'hBBBB, 32'd0, 32'hAAAA}, 3'b100, 1'b1);
        drive("same_b", 3'b001, {5'd10, 5'd0, 5'd10}, {32'hBBBB, 32'd0, 32'hAAAA}, 3'b001, 1'b0);
        drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);

        drive("rst_mid", 3'b100, {5'd7, 5'd0, 5'd0}, {32'h55, 64'd0}, 3'b100, 1'b0);
        // Reset lands before this grant's edge, so the write must never appear.
        void'(exp_q.pop_back());
        #1 RST = 1'b0;
        @(posedge CLK);
        #1 REQ = '0;
        @(negedge CLK);
        chk("rst_mid_gnt", GNT, 3'b000);
        chk("rst_mid_we", RF_WE, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b1;
        drive("post_rst", 3'b111, ADDR3, DATA3, 3'b001, 1'b1);

`ifdef RF_WRITE_ARB_FWD_EN
        RA1 = 5'd9;
        RA2 = 5'd0;
        drive("fwd", 3'b001, {10'd0, 5'd9}, {64'd0, 32'hA5A5A5A5}, 3'b001, 1'b0);
        drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
        chk("fwd1_vld", FWD1_VLD, 1'b1);
        chk("fwd2_vld", FWD2_VLD, 1'b0);
        chk("fwd_data", FWD_DATA, 32'hA5A5A5A5);
        drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
        chk("fwd1_idle", FWD1_VLD, 1'b0);
        chk("fwd2_idle", FWD2_VLD, 1'b0);
        chk("fwd_data_idle", FWD_DATA, 32'd0);
`endif

        drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
        drive("idle", 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
        chk("queue_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
